// File: rtl/instruction_loader.sv
// Program loader for the MiniAlu instruction memory.
// Takes a byte stream (16-bit little-endian word count, then 4 bytes per
// instruction), assembles each instruction and writes it to consecutive
// instruction-RAM addresses. The CPU is held in reset until a load completes.
module instruction_loader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 28,
  parameter int DEPTH       = 256
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStart,
  input  logic [7:0]             iData,
  input  logic                   iValid,
  output logic                   oReady,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oCpuReset,
  output logic                   oDone,
  output logic                   oError
);

  // Number of instruction bits carried by the fourth byte of a word.
  localparam int          TOP_BITS = INSTR_WIDTH - 24;
  localparam logic [31:0] DEPTH_C  = 32'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_LO = 4'd1,
    S_LEN_HI = 4'd2,
    S_BYTE0  = 4'd3,
    S_BYTE1  = 4'd4,
    S_BYTE2  = 4'd5,
    S_BYTE3  = 4'd6,
    S_WRITE  = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  // True when the top byte has a bit set beyond the instruction width.
  function automatic logic top_byte_illegal(input logic [7:0] b);
    logic [7:0] hi;
    hi = b >> TOP_BITS;
    return (hi != 8'd0);
  endfunction

  state_t                 state_q, state_d;
  logic [15:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   ready_q, ready_d;
  logic                   we_q, we_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   take_s;
  logic [15:0]            len_full_s;

  // Next-state logic: handshake, length decode, word assembly and write sequencing.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    take_s     = iValid & ready_q;
    len_full_s = {iData, count_q[7:0]};

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (iStart) begin
          state_d = S_LEN_LO;
          addr_d  = {ADDR_WIDTH{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_LO: begin
        if (take_s) begin
          count_d[7:0] = iData;
          state_d      = S_LEN_HI;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_HI: begin
        if (take_s) begin
          count_d = len_full_s;
          if (len_full_s == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, len_full_s} > DEPTH_C) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_BYTE0;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_BYTE0: begin
        if (take_s) begin
          instr_d[7:0] = iData;
          state_d      = S_BYTE1;
        end else begin
          state_d = state_q;
        end
      end
      S_BYTE1: begin
        if (take_s) begin
          instr_d[15:8] = iData;
          state_d       = S_BYTE2;
        end else begin
          state_d = state_q;
        end
      end
      S_BYTE2: begin
        if (take_s) begin
          instr_d[23:16] = iData;
          state_d        = S_BYTE3;
        end else begin
          state_d = state_q;
        end
      end
      S_BYTE3: begin
        if (take_s) begin
          if (top_byte_illegal(iData)) begin
            state_d = S_ERROR;
          end else begin
            instr_d[INSTR_WIDTH-1:24] = iData[TOP_BITS-1:0];
            state_d                   = S_WRITE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        count_d = count_q - 16'd1;
        if (count_q == 16'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BYTE0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                  (state_d == S_BYTE0)  || (state_d == S_BYTE1)  ||
                  (state_d == S_BYTE2)  || (state_d == S_BYTE3);
    we_d        = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
    cpu_reset_d = (state_d != S_DONE);
  end

  // State and registered outputs with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      count_q     <= 16'd0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      instr_q     <= {INSTR_WIDTH{1'b0}};
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign oReady        = ready_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oInstruction  = instr_q;
  assign oCpuReset     = cpu_reset_q;
  assign oDone         = done_q;
  assign oError        = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: a program-level reference model
// predicts the consumed byte stream, the RAM writes and the final status.
module tb_instruction_loader;

  localparam int DEPTH = 256;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic [7:0]  iData;
  logic        iValid;
  logic        oReady;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oInstruction;
  logic        oCpuReset;
  logic        oDone;
  logic        oError;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [27:0] data;
  } wr_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] stream_q[$];
  bit         exp_done;
  bit         exp_error;
  int         ready_viol  = 0;
  int         strobe_viol = 0;
  logic       prev_we     = 1'b0;

  instruction_loader #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .DEPTH(DEPTH)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStart       (iStart),
    .iData        (iData),
    .iValid       (iValid),
    .oReady       (oReady),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oInstruction (oInstruction),
    .oCpuReset    (oCpuReset),
    .oDone        (oDone),
    .oError       (oError)
  );

  always #5 Clock = ~Clock;

  // Write monitor: records RAM writes and flags strobe/ready misbehaviour.
  always @(negedge Clock) begin
    if (oWriteEnable) begin
      got_q.push_back(wr_t'{addr: oWriteAddress, data: oInstruction});
      if (oReady) ready_viol <= ready_viol + 1;
      if (prev_we) strobe_viol <= strobe_viol + 1;
    end
    prev_we <= oWriteEnable;
  end

  // Reference model: byte stream the loader will consume, writes and final status.
  task automatic model_load(input int cnt, input logic [31:0] words[$]);
    logic [15:0] c16;
    logic [31:0] w;
    wr_t         e;
    c16 = cnt[15:0];
    stream_q.delete();
    exp_q.delete();
    stream_q.push_back(c16[7:0]);
    stream_q.push_back(c16[15:8]);
    exp_done  = 1'b0;
    exp_error = 1'b0;
    if (cnt == 0) begin
      exp_done = 1'b1;
    end else if (cnt > DEPTH) begin
      exp_error = 1'b1;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        w = words[i];
        for (int b = 0; b < 4; b++) stream_q.push_back(w[8*b +: 8]);
        if (w >= 32'h1000_0000) begin
          exp_error = 1'b1;
          break;
        end
        e.addr = 16'(i);
        e.data = w[27:0];
        exp_q.push_back(e);
      end
      if (!exp_error) exp_done = 1'b1;
    end
  endtask

  task automatic pulse_start(input bit with_valid, input logic [7:0] d);
    @(negedge Clock);
    got_q.delete();
    iStart = 1'b1;
    iValid = with_valid;
    iData  = d;
    @(negedge Clock);
    iStart = 1'b0;
    iValid = 1'b0;
  endtask

  // Drives the first nbytes of stream_q, holding each byte until accepted.
  task automatic drive_stream(input bit gaps, input int nbytes, input int start_at);
    int idx;
    int budget;
    idx    = 0;
    budget = 0;
    while (idx < nbytes && budget < 20000) begin
      @(negedge Clock);
      iData  = stream_q[idx];
      iValid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      iStart = (idx == start_at);
      if (iValid && oReady) idx++;
      budget++;
    end
    @(negedge Clock);
    iValid = 1'b0;
    iStart = 1'b0;
    checks++;
    if (idx != nbytes) begin
      errors++;
      $display("FAIL stream_accept: bytes accepted %0d, required %0d", idx, nbytes);
    end
  endtask

  task automatic wait_settle();
    int n;
    n = 0;
    while (!(oDone || oError) && n < 20) begin
      @(negedge Clock);
      n++;
    end
    repeat (3) @(negedge Clock);
  endtask

  task automatic check_load(input string name);
    int n;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got addr=%0h data=%0h, required addr=%0h data=%0h",
                 name, i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (oDone !== exp_done) begin
      errors++;
      $display("FAIL %s_done: got %b, required %b", name, oDone, exp_done);
    end
    checks++;
    if (oError !== exp_error) begin
      errors++;
      $display("FAIL %s_error: got %b, required %b", name, oError, exp_error);
    end
    checks++;
    if (oCpuReset !== !exp_done) begin
      errors++;
      $display("FAIL %s_cpu_reset: got %b, required %b", name, oCpuReset, !exp_done);
    end
    checks++;
    if (oReady !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_idle: got %b, required 0", name, oReady);
    end
    checks++;
    if (ready_viol != 0 || strobe_viol != 0) begin
      errors++;
      $display("FAIL %s_strobe: ready-in-write %0d, back-to-back strobes %0d, required 0 and 0",
               name, ready_viol, strobe_viol);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({oReady, oWriteEnable, oDone, oError, oCpuReset} !== 5'b00001) begin
      errors++;
      $display("FAIL %s_flags: got rdy/we/done/err/cpurst=%b, required 00001", name,
               {oReady, oWriteEnable, oDone, oError, oCpuReset});
    end
    checks++;
    if (oWriteAddress !== 16'd0 || oInstruction !== 28'd0) begin
      errors++;
      $display("FAIL %s_addr_instr: got addr=%0h instr=%0h, required 0 and 0", name,
               oWriteAddress, oInstruction);
    end
  endtask

  task automatic test_reset();
    Reset  = 1'b1;
    iStart = 1'b0;
    iValid = 1'b0;
    iData  = 8'h00;
    repeat (2) @(negedge Clock);
    check_reset_values("reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    check_reset_values("idle");
  endtask

  task automatic test_example();
    logic [31:0] words[$];
    words = {32'h0100_1234, 32'h0234_5678};
    model_load(2, words);
    pulse_start(1'b0, 8'h00);
    drive_stream(1'b0, stream_q.size(), -1);
    wait_settle();
    check_load("example");
    checks++;
    if (got_q.size() != 2 || got_q[0].data !== 28'h100_1234 || got_q[1].data !== 28'h234_5678) begin
      errors++;
      $display("FAIL example_words: got %0d writes, required 1001234 then 2345678", got_q.size());
    end
  endtask

  task automatic test_zero_count();
    logic [31:0] words[$];
    words.delete();
    model_load(0, words);
    pulse_start(1'b0, 8'h00);
    checks++;
    if (oDone !== 1'b0 || oError !== 1'b0 || oCpuReset !== 1'b1 || oWriteAddress !== 16'd0) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b err=%b cpurst=%b addr=%0h, required 0 0 1 0",
               oDone, oError, oCpuReset, oWriteAddress);
    end
    drive_stream(1'b0, stream_q.size(), -1);
    wait_settle();
    check_load("zero_count");
  endtask

  task automatic test_too_long();
    logic [31:0] words[$];
    words.delete();
    model_load(DEPTH + 1, words);
    pulse_start(1'b0, 8'h00);
    drive_stream(1'b0, stream_q.size(), -1);
    wait_settle();
    check_load("too_long");
  endtask

  task automatic test_bad_top();
    logic [31:0] words[$];
    words = {32'hF033_2211};
    model_load(1, words);
    pulse_start(1'b0, 8'h00);
    drive_stream(1'b0, stream_q.size(), -1);
    wait_settle();
    check_load("bad_top");
    words = {32'h0ABC_DEF0, 32'h0000_0001, 32'h0FFF_FFFF};
    model_load(3, words);
    pulse_start(1'b0, 8'h00);
    checks++;
    if (oError !== 1'b0 || oCpuReset !== 1'b1 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_error: got err=%b cpurst=%b done=%b, required 0 1 0",
               oError, oCpuReset, oDone);
    end
    drive_stream(1'b1, stream_q.size(), -1);
    wait_settle();
    check_load("after_error");
  endtask

  task automatic test_random();
    logic [31:0] words[$];
    logic [31:0] w;
    int          cnt;
    int          sel;
    int          start_at;
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) cnt = 0;
      else if (sel == 1) cnt = $urandom_range(DEPTH + 1, 65535);
      else cnt = $urandom_range(1, 7);
      words.delete();
      for (int i = 0; i < cnt && i < 8; i++) begin
        w = {4'h0, 28'($urandom)};
        if ($urandom_range(0, 9) == 0) w[31:28] = 4'($urandom_range(1, 15));
        words.push_back(w);
      end
      model_load(cnt, words);
      start_at = $urandom_range(0, stream_q.size() - 1);
      pulse_start(1'b0, 8'h00);
      drive_stream(1'b1, stream_q.size(), start_at);
      wait_settle();
      check_load("random");
    end
  endtask

  task automatic test_last_address();
    logic [31:0] words[$];
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back({4'h0, 28'($urandom)});
    model_load(DEPTH, words);
    pulse_start(1'b0, 8'h00);
    drive_stream(1'b0, stream_q.size(), -1);
    wait_settle();
    check_load("last_addr");
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size() - 1].addr !== 16'(DEPTH - 1)) begin
      errors++;
      $display("FAIL last_addr_value: got %0d writes, required final address %0d",
               got_q.size(), DEPTH - 1);
    end
  endtask

  task automatic test_midload_reset();
    logic [31:0] words[$];
    words = {32'h0AAB_BCCD};
    model_load(1, words);
    pulse_start(1'b0, 8'h00);
    drive_stream(1'b0, 4, -1);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge Clock);
    Reset = 1'b0;
    words = {32'h0123_4567, 32'h0765_4321};
    model_load(2, words);
    pulse_start(1'b1, 8'h05);
    drive_stream(1'b1, stream_q.size(), -1);
    wait_settle();
    check_load("after_reset");
  endtask

  initial begin
    test_reset();
    test_example();
    test_zero_count();
    test_too_long();
    test_bad_top();
    test_random();
    test_last_address();
    test_midload_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
